sum_to_bcd_converter: RTL and testbench

Sequential binary-to-BCD converter sitting directly downstream of the 4-bit ripple adder. It captures the adder's 5-bit result (carry K plus sum bits Z8..Z1) on a start request and converts it to two BCD digits (tens, ones) by shift-and-add-3 (double dabble), one bit per clock. The digits feed the display / BCD stage; a start/busy/done handshake paces the operation.

---
 rtl/sum_to_bcd_converter_pkg.sv | 22 ++
 rtl/sum_to_bcd_converter_bcd_digit_adjust.sv | 14 +
 rtl/sum_to_bcd_converter.sv | 99 +++++++++
 tb/tb_sum_to_bcd_converter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sum_to_bcd_converter_pkg.sv
// Shared definitions for the sum-to-BCD converter: FSM encoding,
// double-dabble adjust constants and the legal input width range.
// No ports; imported by the top and the digit-adjust sub-module.
package sum_to_bcd_converter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A digit at or above this value is bumped before each shift so the
  // shift carries into the next decade correctly.
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

  // Two BCD digits cover values up to 99; 6 bits (63) is the largest
  // width kept legal so TENS never needs more than one digit.
  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 6;

endpackage

// File: rtl/sum_to_bcd_converter_bcd_digit_adjust.sv
// Combinational double-dabble digit correction: add 3 when digit >= 5.
// Ports: digit_in (4-bit BCD scratch digit), digit_out (corrected digit).
// Inputs are at most 9, so the result fits in 4 bits with no carry out.
module bcd_digit_adjust
  import sum_to_bcd_converter_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  assign digit_out = (digit_in >= BCD_ADJ_THRESH) ? (digit_in + BCD_ADJ_ADD)
                                                  : digit_in;

endmodule

// File: rtl/sum_to_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Ports: clk, rst (async high), start, SUM in; TENS, ONES, busy, done out.
// Latency: start accepted at edge N -> TENS/ONES and done after edge N+WIDTH.
module sum_to_bcd_converter
  import sum_to_bcd_converter_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] SUM,
  output logic [3:0]       TENS,
  output logic [3:0]       ONES,
  output logic             busy,
  output logic             done
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("sum_to_bcd_converter: WIDTH=%0d outside legal range %0d..%0d",
           WIDTH, WIDTH_MIN, WIDTH_MAX);
  end

  localparam int ACC_W = 8 + WIDTH;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] bin;
  logic [3:0]       tens_s, ones_s;
  logic [3:0]       tens_adj, ones_adj;
  logic [2:0]       cnt;
  logic [ACC_W-1:0] acc_shl;
  logic [3:0]       tens_nxt, ones_nxt;
  logic [WIDTH-1:0] bin_nxt;

  bcd_digit_adjust u_adj_tens (.digit_in(tens_s), .digit_out(tens_adj));
  bcd_digit_adjust u_adj_ones (.digit_in(ones_s), .digit_out(ones_adj));

  // Adjusted digits and the binary remainder shift together as one word;
  // the tens MSB falls off, which is safe since tens stays below 8.
  assign acc_shl  = {tens_adj, ones_adj, bin} << 1;
  assign tens_nxt = acc_shl[ACC_W-1:WIDTH+4];
  assign ones_nxt = acc_shl[WIDTH+3:WIDTH];
  assign bin_nxt  = acc_shl[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_SHIFT;
      ST_SHIFT: if (cnt == 3'd1) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin    <= '0;
      tens_s <= 4'd0;
      ones_s <= 4'd0;
      cnt    <= 3'd0;
      TENS   <= 4'd0;
      ONES   <= 4'd0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            bin    <= SUM;
            tens_s <= 4'd0;
            ones_s <= 4'd0;
            cnt    <= 3'(WIDTH);
          end
        end
        ST_SHIFT: begin
          tens_s <= tens_nxt;
          ones_s <= ones_nxt;
          bin    <= bin_nxt;
          cnt    <= cnt - 3'd1;
          // Last shift: publish the digits and raise done for the DONE cycle.
          if (cnt == 3'd1) begin
            TENS <= tens_nxt;
            ONES <= ones_nxt;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_to_bcd_converter.sv
// Testbench for sum_to_bcd_converter: default-width and 6-bit instances,
// checked against a decimal-arithmetic reference (value / 10, value % 10).
module tb_sum_to_bcd_converter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [4:0] sum_a;
  logic [5:0] sum_b;
  logic [3:0] tens_a, ones_a, tens_b, ones_b;
  logic       busy_a, done_a, busy_b, done_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sum_to_bcd_converter #(.WIDTH(5)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .SUM(sum_a),
    .TENS(tens_a), .ONES(ones_a), .busy(busy_a), .done(done_a)
  );

  sum_to_bcd_converter #(.WIDTH(6)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .SUM(sum_b),
    .TENS(tens_b), .ONES(ones_b), .busy(busy_b), .done(done_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full conversion on the selected instance, started on the first
  // IDLE cycle; checks latency, busy length, done pulse and the digits.
  task automatic conv(input bit w6, input int v, input string tag);
    int n;
    int busy_cnt;
    int w;
    w = w6 ? 6 : 5;
    n = 0;
    while ((w6 ? (busy_b | done_b) : (busy_a | done_a)) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, w6 ? (busy_b | done_b) : (busy_a | done_a), 0);
    if (w6) begin sum_b = 6'(v); start_b = 1'b1; end
    else    begin sum_a = 5'(v); start_a = 1'b1; end
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    n = 0;
    busy_cnt = 0;
    while (!(w6 ? done_b : done_a) && n < 20) begin
      if (w6 ? busy_b : busy_a) busy_cnt++;
      tick();
      n++;
    end
    check({tag, "_latency"}, n, w);
    check({tag, "_busy_cycles"}, busy_cnt, w);
    check({tag, "_tens"}, w6 ? tens_b : tens_a, v / 10);
    check({tag, "_ones"}, w6 ? ones_b : ones_a, v % 10);
    check({tag, "_busy_in_done"}, w6 ? busy_b : busy_a, 0);
    tick();
    check({tag, "_done_pulse"}, w6 ? done_b : done_a, 0);
    check({tag, "_tens_hold"}, w6 ? tens_b : tens_a, v / 10);
  endtask

  initial begin
    int v;
    int n;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sum_a = '0;
    sum_b = '0;
    tick();
    tick();
    check("rst_tens", tens_a, 0);
    check("rst_ones", ones_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("idle_no_activity", {busy_a, done_a}, 0);
    end

    conv(1'b0, 30, "sum30");
    conv(1'b0, 0,  "b0");
    conv(1'b0, 9,  "b9");
    conv(1'b0, 10, "b10");
    conv(1'b0, 19, "b19");
    conv(1'b0, 31, "b31");
    for (int i = 0; i < 8; i++) begin
      v = int'($urandom_range(0, 31));
      conv(1'b0, v, "rand5");
    end

    // start held high: a new conversion every WIDTH+2 cycles, with SUM
    // disturbed mid-shift to show it is captured only at acceptance.
    sum_a = 5'd25;
    start_a = 1'b1;
    tick();
    check("held_accept_busy", busy_a, 1);
    for (int c = 1; c <= 21; c++) begin
      if (c % 7 == 2) sum_a = 5'd7;
      if (c % 7 == 4) sum_a = 5'd25;
      tick();
      check("held_done_timing", done_a, (c % 7 == 5) ? 1 : 0);
      check("held_busy_done_excl", busy_a & done_a, 0);
      if (done_a) begin
        check("held_tens", tens_a, 2);
        check("held_ones", ones_a, 5);
      end
    end
    start_a = 1'b0;

    // Reset in the middle of a conversion.
    n = 0;
    while ((busy_a | done_a) && n < 20) begin tick(); n++; end
    sum_a = 5'd22;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_tens", tens_a, 0);
    check("midrst_ones", ones_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_done", done_a, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_done", done_a, 0);
    end
    conv(1'b0, 14, "after_rst14");

    conv(1'b1, 63, "w6_63");
    conv(1'b1, 40, "w6_40");
    for (int i = 0; i < 6; i++) begin
      v = int'($urandom_range(0, 63));
      conv(1'b1, v, "rand6");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
